// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Sends one command byte
//                (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the
//                keyboard by driving PS2_CLK / PS2_DAT as open-drain
//                pull-low enables. While busy the host owns the bus and the
//                receive path must ignore line activity.
//  Ports       : CLOCK_50    - system clock (50 MHz)
//                resetn      - asynchronous active-low reset
//                send        - one-cycle request, accepted only when idle
//                tx_data     - byte to send, sampled when send is accepted
//                ps2_clk_in  - raw PS2_CLK line level
//                ps2_dat_in  - raw PS2_DAT line level
//                ps2_clk_oe  - 1 = pull PS2_CLK low
//                ps2_dat_oe  - 1 = pull PS2_DAT low
//                busy        - transfer in progress
//                done        - one-cycle pulse, byte sent and ACK seen
//                error       - one-cycle pulse, timeout or missing ACK
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int EDGE_TIMEOUT   = 750000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // One counter serves both the inhibit delay and the edge timeout.
    localparam int c_cnt_max = (INHIBIT_CYCLES > EDGE_TIMEOUT) ? INHIBIT_CYCLES : EDGE_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_inhibit_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(EDGE_TIMEOUT - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_inhibit   = 3'd1;
    localparam logic [2:0] c_st_rts       = 3'd2;
    localparam logic [2:0] c_st_bits      = 3'd3;
    localparam logic [2:0] c_st_ack       = 3'd4;
    localparam logic [2:0] c_st_wait_idle = 3'd5;
    localparam logic [2:0] c_st_fail      = 3'd6;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;
    logic       w_clk_s;
    logic       w_dat_s;
    logic       w_fall;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [9:0]         r_frame;
    logic [3:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic [2:0]         w_nxt_state;
    logic [9:0]         w_nxt_frame;
    logic [3:0]         w_nxt_idx;
    logic [c_cnt_w-1:0] w_nxt_cnt;
    logic               w_nxt_clk_oe;
    logic               w_nxt_dat_oe;
    logic               w_nxt_busy;
    logic               w_nxt_done;
    logic               w_nxt_error;

    logic               w_timeout;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign w_timeout = (r_cnt == c_timeout_last);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_st_idle;
            r_frame  <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_frame  <= w_nxt_frame;
            r_idx    <= w_nxt_idx;
            r_cnt    <= w_nxt_cnt;
            r_clk_oe <= w_nxt_clk_oe;
            r_dat_oe <= w_nxt_dat_oe;
            r_busy   <= w_nxt_busy;
            r_done   <= w_nxt_done;
            r_error  <= w_nxt_error;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_frame  = r_frame;
        w_nxt_idx    = r_idx;
        w_nxt_cnt    = r_cnt;
        w_nxt_clk_oe = r_clk_oe;
        w_nxt_dat_oe = r_dat_oe;
        w_nxt_busy   = r_busy;
        w_nxt_done   = 1'b0;
        w_nxt_error  = 1'b0;

        case (r_state)
            c_st_idle: begin
                // The cycle carrying done is still IDLE; a request that lands
                // there is deliberately dropped.
                if (send && !r_done && !r_error) begin
                    w_nxt_frame  = {1'b1, ~^tx_data, tx_data};
                    w_nxt_clk_oe = 1'b1;
                    w_nxt_busy   = 1'b1;
                    w_nxt_cnt    = '0;
                    w_nxt_state  = c_st_inhibit;
                end
            end

            c_st_inhibit: begin
                if (r_cnt == c_inhibit_last) begin
                    w_nxt_dat_oe = 1'b1;    // start bit
                    w_nxt_state  = c_st_rts;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end

            c_st_rts: begin
                w_nxt_clk_oe = 1'b0;
                w_nxt_idx    = '0;
                w_nxt_cnt    = '0;
                w_nxt_state  = c_st_bits;
            end

            c_st_bits: begin
                if (w_fall) begin
                    // Stop bit is frame[9]=1, so the line is released for it.
                    w_nxt_dat_oe = ~r_frame[r_idx];
                    w_nxt_idx    = r_idx + 4'd1;
                    w_nxt_cnt    = '0;
                    if (r_idx == 4'd9) begin
                        w_nxt_state = c_st_ack;
                    end
                end else if (w_timeout) begin
                    w_nxt_clk_oe = 1'b0;
                    w_nxt_dat_oe = 1'b0;
                    w_nxt_busy   = 1'b0;
                    w_nxt_error  = 1'b1;
                    w_nxt_state  = c_st_fail;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end

            c_st_ack: begin
                if (w_fall) begin
                    if (!w_dat_s) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = c_st_wait_idle;
                    end else begin
                        w_nxt_clk_oe = 1'b0;
                        w_nxt_dat_oe = 1'b0;
                        w_nxt_busy   = 1'b0;
                        w_nxt_error  = 1'b1;
                        w_nxt_state  = c_st_fail;
                    end
                end else if (w_timeout) begin
                    w_nxt_clk_oe = 1'b0;
                    w_nxt_dat_oe = 1'b0;
                    w_nxt_busy   = 1'b0;
                    w_nxt_error  = 1'b1;
                    w_nxt_state  = c_st_fail;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end

            c_st_wait_idle: begin
                if (w_clk_s && w_dat_s) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_busy  = 1'b0;
                    w_nxt_state = c_st_idle;
                end else if (w_timeout) begin
                    w_nxt_clk_oe = 1'b0;
                    w_nxt_dat_oe = 1'b0;
                    w_nxt_busy   = 1'b0;
                    w_nxt_error  = 1'b1;
                    w_nxt_state  = c_st_fail;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end

            c_st_fail: begin
                // Lines, busy and the error pulse were all set on entry, so
                // they are visible for exactly this one cycle.
                w_nxt_state = c_st_idle;
            end

            default: begin
                w_nxt_clk_oe = 1'b0;
                w_nxt_dat_oe = 1'b0;
                w_nxt_busy   = 1'b0;
                w_nxt_state  = c_st_idle;
            end
        endcase
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device
//                model; expected frame bits and transfer outcomes are queued
//                when stimulus is driven and checked as the device sees them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 400;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic       send    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .EDGE_TIMEOUT   (TMO)
    ) u_dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .send       (send),
        .tx_data    (tx_data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    bit   exp_outcome_q[$];   // 0 = done expected, 1 = error expected

    // Monitor (single writer of its variables)
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   err_cyc = 0;
    logic err_busy = 1'b0;
    logic err_prev_busy = 1'b0;
    logic err_clk_oe = 1'b0;
    logic err_dat_oe = 1'b0;
    logic prev_busy = 1'b0;

    int   snap_done = 0;
    int   snap_err = 0;
    int   rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) begin
            err_cnt       <= err_cnt + 1;
            err_cyc       <= cyc;
            err_busy      <= busy;
            err_prev_busy <= prev_busy;
            err_clk_oe    <= ps2_clk_oe;
            err_dat_oe    <= ps2_dat_oe;
        end
        if (done && error) both_cnt <= both_cnt + 1;
        prev_busy <= busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_send(input logic [7:0] b);
        send    = 1'b1;
        tx_data = b;
        @(posedge clk);
        #1;
        send = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        snap_done = done_cnt;
        snap_err  = err_cnt;
    endtask

    task automatic wait_rts();
        int n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < 200) begin
            step();
            n++;
        end
        rel_cyc = cyc;
        check("rts_seen", 32'(ps2_dat_oe && !ps2_clk_oe), 32'd1);
    endtask

    task automatic sb_check_bit(input int b);
        logic e;
        string tag;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        tag = (b < 8) ? $sformatf("data%0d", b) : ((b == 8) ? "parity" : "stop");
        check(tag, 32'(ps2_dat_in), 32'(e));
    endtask

    // Device generates nclk clock pulses (40-cycle period) sampling data on
    // each rising edge; with a full frame it then runs the ACK clock.
    task automatic device_frame(input bit give_ack, input int nclk);
        repeat (10) step();
        for (int b = 0; b < nclk; b++) begin
            dev_clk = 1'b0;
            repeat (20) step();
            dev_clk = 1'b1;
            sb_check_bit(b);
            repeat (20) step();
        end
        if (nclk == 10) begin
            exp_outcome_q.push_back(!give_ack);
            if (give_ack) dev_dat = 1'b0;
            repeat (5) step();
            dev_clk = 1'b0;
            repeat (20) step();
            dev_clk = 1'b1;
            repeat (5) step();
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_outcome();
        int n = 0;
        bit exp_err;
        if (exp_outcome_q.size() == 0) begin
            check("outcome_q_empty", 32'd1, 32'd0);
            return;
        end
        exp_err = exp_outcome_q.pop_front();
        while (done_cnt == snap_done && err_cnt == snap_err && n < TMO + 200) begin
            step();
            n++;
        end
        check("outcome_seen", 32'(n < TMO + 200), 32'd1);
        repeat (3) step();
        check("done_pulses", 32'(done_cnt - snap_done), exp_err ? 32'd0 : 32'd1);
        check("error_pulses", 32'(err_cnt - snap_err), exp_err ? 32'd1 : 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("clk_oe_after", 32'(ps2_clk_oe), 32'd0);
        check("dat_oe_after", 32'(ps2_dat_oe), 32'd0);
        check("done_and_error", 32'(both_cnt), 32'd0);
    endtask

    initial begin
        int n;
        int m;

        // Reset state
        resetn = 1'b0;
        repeat (3) step();
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        resetn = 1'b1;
        repeat (3) step();

        // Nominal transfer of 0xED with inhibit/RTS timing
        do_send(8'hED);
        check("busy_accept", 32'(busy), 32'd1);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
            n++;
            step();
        end
        check("inhibit_len", 32'(n), 32'(INH));
        m = 0;
        while (ps2_clk_oe && ps2_dat_oe && m < 10) begin
            m++;
            step();
        end
        check("rts_len", 32'(m), 32'd1);
        check("start_bit", 32'(ps2_dat_oe), 32'd1);
        device_frame(1'b1, 10);
        wait_outcome();

        // Parity patterns
        do_send(8'h00); wait_rts(); device_frame(1'b1, 10); wait_outcome();
        do_send(8'h01); wait_rts(); device_frame(1'b1, 10); wait_outcome();
        do_send(8'hFF); wait_rts(); device_frame(1'b1, 10); wait_outcome();

        // Busy rejection: second request during INHIBIT must be dropped
        do_send(8'hED);
        repeat (10) step();
        send    = 1'b1;
        tx_data = 8'hAA;
        step();
        send = 1'b0;
        check("busy_during_inhibit", 32'(busy), 32'd1);
        wait_rts();
        device_frame(1'b1, 10);
        wait_outcome();

        // Missing ACK
        do_send(8'h3C); wait_rts(); device_frame(1'b0, 10); wait_outcome();
        check("nack_err_clk_oe", 32'(err_clk_oe), 32'd0);
        check("nack_err_dat_oe", 32'(err_dat_oe), 32'd0);

        // Device silent after RTS
        do_send(8'hF4);
        wait_rts();
        exp_outcome_q.push_back(1'b1);
        wait_outcome();
        exp_q.delete();
        check("timeout_latency", 32'(err_cyc - rel_cyc), 32'(TMO));
        check("timeout_busy_at_err", 32'(err_busy), 32'd0);
        check("timeout_busy_before", 32'(err_prev_busy), 32'd1);
        check("timeout_clk_oe", 32'(err_clk_oe), 32'd0);
        check("timeout_dat_oe", 32'(err_dat_oe), 32'd0);

        // Reset mid-frame after fall 5 (bit 4 of 0xED is 0 -> dat pulled low)
        do_send(8'hED);
        wait_rts();
        device_frame(1'b1, 5);
        check("mid_dat_oe", 32'(ps2_dat_oe), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        step();
        step();
        resetn = 1'b1;
        repeat (3) step();
        do_send(8'h5A); wait_rts(); device_frame(1'b1, 10); wait_outcome();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED set-LEDs, 0xFF reset, or 0xF4 enable.
- It is the outbound counterpart of the PS/2 receive path that feeds the keyboard note decoder.
- It drives the PS2_CLK/PS2_DAT lines as open-drain through separate pull-low enables. The top level builds the tristate as line = oe ? 1'b0 : 1'bz.
- While busy it owns the bus; the receive path must ignore traffic during that time.

Parameters:
- INHIBIT_CYCLES, 5000: cycles PS2_CLK is held low before the start bit (100 us at 50 MHz).
- EDGE_TIMEOUT, 750000: maximum cycles to wait for any expected device event (15 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous, active-low reset.
- send  input  1  single-cycle request; accepted only while busy=0.
- tx_data  input  8  byte to transmit; sampled in the cycle send is accepted.
- ps2_clk_in  input  1  raw PS2_CLK line level.
- ps2_dat_in  input  1  raw PS2_DAT line level.
- ps2_clk_oe  output  1  1 = pull PS2_CLK low.
- ps2_dat_oe  output  1  1 = pull PS2_DAT low.
- busy  output  1  high from the cycle after acceptance until done or error.
- done  output  1  one-cycle pulse: byte sent and ACK seen.
- error  output  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset is asynchronous, active-low, and honoured in any state. On reset:
  - state=IDLE;
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0;
  - counters cleared and synchronisers set to 1.
- Reset asserted mid-frame releases both lines immediately, with no partial-frame cleanup.
- Input conditioning:
  - Each raw line passes through a 2-FF synchroniser.
  - A clock falling edge (fall) is synchronised clock 1 in the previous cycle and 0 in the current cycle. Latency is 3 cycles from the raw edge.
- Frame: shift register = {stop=1, parity=~^tx_data, tx_data}, sent LSB first. This is odd parity.
- IDLE:
  - send=1 latches the frame, sets ps2_clk_oe=1 and busy=1, clears the counter, and goes to INHIBIT.
  - send while busy is ignored.
- INHIBIT:
  - Count to INHIBIT_CYCLES-1, then set ps2_dat_oe=1 (start bit) and go to RTS.
- RTS:
  - Hold for exactly 1 cycle, then set ps2_clk_oe=0 (release clock) and go to BITS with bit index=0.
- BITS:
  - On each fall: ps2_dat_oe = ~frame[idx]; idx increments.
  - Falls 1..8 carry data, fall 9 carries parity, fall 10 carries stop (dat_oe=0).
  - After fall 10, go to ACK.
- ACK:
  - On the next fall, sample synchronised data. 0 goes to WAIT_IDLE; 1 goes to FAIL.
- WAIT_IDLE:
  - Wait until synchronised clock=1 and data=1 in the same cycle, then pulse done=1, clear busy, and return to IDLE.
- Timeout:
  - The counter restarts at the entry to BITS, at every fall, and at the entry to WAIT_IDLE.
  - Reaching EDGE_TIMEOUT in BITS, ACK, or WAIT_IDLE goes to FAIL.
- FAIL:
  - Release both lines, pulse error=1, clear busy, and return to IDLE, all in 1 cycle.
  - done and error are never asserted together.
- send in the same cycle as done or error is ignored; busy is cleared in that cycle.
- Fall edges arriving during INHIBIT or RTS are ignored.

Test Plan:
- Nominal transfer. Set INHIBIT_CYCLES=20, EDGE_TIMEOUT=400. Send 0xED; the device model clocks at a 40-cycle period and ACKs low.
  - clk_oe is high for exactly 20 cycles; dat_oe rises; clk_oe releases 1 cycle later.
  - Sampled bits are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses exactly once, after the lines idle; busy=0 afterwards.
- Parity. Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Send 0xFF → parity bit 1.
- Missing ACK. The device leaves data high at fall 11 → error=1 for 1 cycle, done stays 0, both oe=0.
- Device silent. No clock edges after RTS → error pulses exactly 400 cycles after clock release; busy falls in the same cycle.
- Reset mid-frame. Assert resetn=0 after fall 5 → both oe and busy go to 0 combinationally-asynchronously. A fresh send after release sends a clean full frame.
- Busy rejection. A second send 10 cycles into INHIBIT with 0xAA is ignored; the transmitted byte remains the first one, 0xED.
